sram_test_seq: RTL and testbench



---
 rtl/sram_test_seq.sv | 172 +++++++++++++++++
 tb/tb_sram_test_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_test_seq.sv
// sram_test_seq: data-background self-test sequencer for the SRAM controller.
// Optional build macro SRAM_TEST_SEQ_STOP_ON_ERR_EN ends the run at the first mismatch.
module sram_test_seq #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        pat_mask,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+2:0] err_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data,
    output logic [7:0]        cmd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] inp_data,
    input  logic [DATA_W-1:0] outp_data,
    input  logic              busy
);

    localparam logic [7:0] C_NONE = 8'hFF;
    localparam logic [7:0] C_WR   = 8'hC0;
    localparam logic [7:0] C_RD   = 8'h80;
    localparam int         CW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] W_LAST = CW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, SEL, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE
    } state_t;

    state_t              state;
    logic [3:0]          mask;
    logic [2:0]          pidx;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   pattern;
    logic [CW-1:0]       wcnt;
    logic                sel_ok;
    logic [1:0]          sel_idx;
    logic                miss;

    function automatic logic [DATA_W-1:0] pat_of(input logic [1:0] i);
        logic [DATA_W-1:0] p;
        unique case (i)
            2'd0: p = '0;
            2'd1: p = '1;
            2'd2: p = DATA_W'(8'h5A);
            2'd3: p = DATA_W'(8'hA5);
        endcase
        return p;
    endfunction

    // Pick the lowest selected pattern at or above the current index
    always_comb begin
        sel_ok  = 1'b0;
        sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= pidx)) begin
                sel_ok  = 1'b1;
                sel_idx = 2'(i);
            end
        end
    end

    assign miss = (outp_data != pattern);

    // Sequencer FSM with registered bus and result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mask     <= '0;
            pidx     <= '0;
            cur_addr <= '0;
            pattern  <= '0;
            wcnt     <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
            err_data <= '0;
            cmd      <= C_NONE;
            addr     <= '0;
            inp_data <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mask     <= pat_mask;
                        pidx     <= '0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err_cnt  <= '0;
                        err_addr <= '0;
                        err_data <= '0;
                        state    <= SEL;
                    end
                end
                SEL: begin
                    if (sel_ok) begin
                        pattern  <= pat_of(sel_idx);
                        pidx     <= {1'b0, sel_idx};
                        cur_addr <= '0;
                        state    <= WR_ISSUE;
                    end else begin
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0);
                        state <= DONE;
                    end
                end
                WR_ISSUE: begin
                    if (!busy) begin
                        cmd      <= C_WR;
                        addr     <= cur_addr;
                        inp_data <= pattern;
                        wcnt     <= '0;
                        state    <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    cmd <= C_NONE;
                    if (wcnt == W_LAST) begin
                        cur_addr <= cur_addr + 1'b1;
                        state    <= (cur_addr == '1) ? RD_ISSUE : WR_ISSUE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                RD_ISSUE: begin
                    if (!busy) begin
                        cmd   <= C_RD;
                        addr  <= cur_addr;
                        wcnt  <= '0;
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    cmd <= C_NONE;
                    if (wcnt == W_LAST) begin
                        if (miss) begin
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + 1'b1;
                            if (err_cnt == '0) begin
                                err_addr <= cur_addr;
                                err_data <= outp_data;
                            end
                        end
`ifdef SRAM_TEST_SEQ_STOP_ON_ERR_EN
                        if (miss) begin
                            done  <= 1'b1;
                            pass  <= 1'b0;
                            state <= DONE;
                        end else
`endif
                        if (cur_addr == '1) begin
                            pidx  <= pidx + 3'd1;
                            state <= SEL;
                        end else begin
                            cur_addr <= cur_addr + 1'b1;
                            state    <= RD_ISSUE;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_test_seq.sv
// tb_sram_test_seq: scoreboard bench with an SRAM model and stuck-at faults.
// Expected command stream and results come from a pattern-level reference model.
module tb_sram_test_seq;

    localparam logic [7:0] C_WR = 8'hC0;
    localparam logic [7:0] C_RD = 8'h80;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  pat_mask;
    logic        done;
    logic        pass;
    logic [12:0] err_cnt;
    logic [9:0]  err_addr;
    logic [7:0]  err_data;
    logic [7:0]  cmd;
    logic [9:0]  addr;
    logic [7:0]  inp_data;
    logic [7:0]  outp_data;
    logic        busy;

    sram_test_seq dut (
        .clk(clk), .reset(reset), .start(start), .pat_mask(pat_mask),
        .done(done), .pass(pass), .err_cnt(err_cnt),
        .err_addr(err_addr), .err_data(err_data),
        .cmd(cmd), .addr(addr), .inp_data(inp_data),
        .outp_data(outp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c;
        logic [9:0] a;
        logic [7:0] d;
    } cmd_t;

    typedef struct {
        logic [12:0] cnt;
        logic [9:0]  a;
        logic [7:0]  d;
        logic        p;
    } res_t;

    cmd_t exp_q[$];
    res_t res_q[$];

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [1024];
    logic [7:0] sa1 [1024];
    logic [7:0] sa0 [1024];
    logic [7:0] rdata;
    logic       busy_at_edge;
    logic       rnd_en;
    int         arm_id;
    logic [9:0] arm_addr;

    assign outp_data = rdata;

    // SRAM model behind the controller: one-cycle read latency, stuck-at faults on read
    always @(posedge clk) begin
        if (cmd == C_WR) mem[addr] <= inp_data;
        if (cmd == C_RD) rdata <= (mem[addr] | sa1[addr]) & ~sa0[addr];
    end

    always @(posedge clk) busy_at_edge <= busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 1024; i++) begin
            sa1[i] = 8'h00;
            sa0[i] = 8'h00;
        end
    endtask

    // Reference: every selected background is written over all addresses, then read back
    task automatic build_expect(input logic [3:0] m);
        logic [7:0] pats [4];
        int         cnt;
        logic [9:0] ea;
        logic [7:0] ed;
        logic [7:0] rd;
        bit         stop;
        cmd_t       e;
        res_t       r;
        pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h5A; pats[3] = 8'hA5;
        cnt = 0; ea = '0; ed = '0; stop = 0;
        for (int p = 0; p < 4; p++) begin
            if (m[p] && !stop) begin
                for (int a = 0; a < 1024; a++) begin
                    e.c = C_WR; e.a = 10'(a); e.d = pats[p];
                    exp_q.push_back(e);
                end
                for (int a = 0; a < 1024 && !stop; a++) begin
                    e.c = C_RD; e.a = 10'(a); e.d = 8'h00;
                    exp_q.push_back(e);
                    rd = (pats[p] | sa1[a]) & ~sa0[a];
                    if (rd != pats[p]) begin
                        if (cnt == 0) begin
                            ea = 10'(a);
                            ed = rd;
                        end
                        if (cnt < 8191) cnt++;
`ifdef SRAM_TEST_SEQ_STOP_ON_ERR_EN
                        stop = 1;
`endif
                    end
                end
            end
        end
        r.cnt = 13'(cnt); r.a = ea; r.d = ed; r.p = (cnt == 0);
        res_q.push_back(r);
    endtask

    task automatic pulse_start(input logic [3:0] m);
        pat_mask = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input logic [3:0] m);
        int n;
        build_expect(m);
        pulse_start(m);
        n = 0;
        while (!done && n < 40000) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("cmds_left", exp_q.size(), 0);
    endtask

    // Busy driver: random single-cycle stalls plus one armed 20-cycle stall in RD_ISSUE
    initial begin
        int pend;
        int long_cnt;
        int seen_id;
        pend = 0; long_cnt = 0; seen_id = 0;
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (pend > 0) begin
                pend--;
                if (pend == 0) long_cnt = 20;
            end
            if (arm_id != seen_id && cmd == C_RD && addr == arm_addr) begin
                seen_id = arm_id;
                pend = 3;
            end
            if (long_cnt > 0) begin
                busy = 1'b1;
                long_cnt--;
            end else begin
                busy = rnd_en && ($urandom_range(0, 31) == 0);
            end
        end
    end

    // Monitor: pops expected commands and results as the DUT presents them
    initial begin
        logic prev_done;
        int   run_len;
        cmd_t e;
        res_t r;
        prev_done = 1'b0;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_done = 1'b0;
                run_len = 0;
            end else begin
                if (cmd != 8'hFF) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_cmd", {24'd0, cmd}, 32'hFF);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.c == C_WR)
                            chk("write_cmd", {6'd0, cmd, addr, inp_data},
                                {6'd0, e.c, e.a, e.d});
                        else
                            chk("read_cmd", {14'd0, cmd, addr}, {14'd0, e.c, e.a});
                        chk("issue_while_busy", {31'd0, busy_at_edge}, 32'd0);
                    end
                end
                if (busy_at_edge) begin
                    run_len++;
                end else begin
                    if (run_len >= 20)
                        chk("stall_release_cmd", {24'd0, cmd}, {24'd0, C_RD});
                    run_len = 0;
                end
                if (done && !prev_done) begin
                    if (res_q.size() == 0) begin
                        chk("unexpected_done", {31'd0, done}, 32'd0);
                    end else begin
                        r = res_q.pop_front();
                        chk("err_cnt", {19'd0, err_cnt}, {19'd0, r.cnt});
                        chk("err_addr", {22'd0, err_addr}, {22'd0, r.a});
                        chk("err_data", {24'd0, err_data}, {24'd0, r.d});
                        chk("pass", {31'd0, pass}, {31'd0, r.p});
                    end
                end
                prev_done = done;
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd"}, {24'd0, cmd}, 32'hFF);
        chk({tag, "_addr"}, {22'd0, addr}, 32'd0);
        chk({tag, "_inp_data"}, {24'd0, inp_data}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_err_cnt"}, {19'd0, err_cnt}, 32'd0);
        chk({tag, "_err_addr"}, {22'd0, err_addr}, 32'd0);
        chk({tag, "_err_data"}, {24'd0, err_data}, 32'd0);
    endtask

    initial begin
        int n;
        logic [3:0] m;
        reset = 1'b1; start = 1'b0; pat_mask = 4'd0;
        rnd_en = 1'b0; arm_id = 0; arm_addr = '0;
        clear_faults();
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        rnd_en = 1'b1;

        run(4'b1111);

        sa1[10'h155] = 8'h08;
        arm_addr = 10'h12C;
        arm_id = 1;
        run(4'b0001);
        clear_faults();

        sa0[10'h3FF] = 8'hFF;
        run(4'b1110);
        clear_faults();

        build_expect(4'b0000);
        pulse_start(4'b0000);
        chk("mask0_done_n1", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("mask0_done_n2", {31'd0, done}, 32'd1);
        chk("mask0_pass_n2", {31'd0, pass}, 32'd1);
        @(negedge clk);

        m = 4'(1 << $urandom_range(0, 3));
        build_expect(m);
        pulse_start(m);
        n = 0;
        while (!(cmd == C_WR && addr == 10'h080) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wr_080", {22'd0, addr}, 32'h080);
        reset = 1'b1;
        #1;
        chk_reset_vals("midreset");
        exp_q.delete();
        res_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(4'b0100);
        chk("after_reset_pass", {31'd0, pass}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
